// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes enter a FIFO through a write strobe. Frames are sent LSB first,
// back-to-back while the FIFO holds data and i_en is high.
// Optional build macro UART_TX_FIFO_PARITY_EN inserts an even-parity bit
// after the data bits, giving 8E1 frames.
module uart_tx_fifo #(
  parameter int p_BAUDRATE   = 9600,
  parameter int p_CLK_FREQ   = 12000000,
  parameter int p_FIFO_DEPTH = 16,
  parameter int p_STOP_BITS  = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_en,
  input  logic                            i_wr_en,
  input  logic [7:0]                      i8_wrdata,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(p_FIFO_DEPTH):0]   o_count,
  output logic                            o_overflow,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_uart_tx
);

  // Clocks per bit, rounded to nearest.
  localparam int CPB      = (p_CLK_FREQ + p_BAUDRATE / 2) / p_BAUDRATE;
  localparam int STOP_LEN = p_STOP_BITS * CPB;
  localparam int AW       = $clog2(p_FIFO_DEPTH);
  localparam int CW       = $clog2(STOP_LEN);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [p_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  // Transmitter state
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_TX_FIFO_PARITY_EN
  logic          r_parity;
`endif

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_start_ok;
  logic          w_bit_end;
  logic          w_stop_end;
  logic [7:0]    w_head;

  assign w_full     = (r_count == (AW + 1)'(p_FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // Full is judged on pre-edge occupancy, so a same-cycle pop never frees a slot.
  assign w_push     = i_wr_en && !w_full;
  assign w_start_ok = !w_empty && i_en;
  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_stop_end = (r_cnt == STOP_LAST);
  assign w_pop      = w_start_ok &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));
  assign w_head     = r_mem[r_rd_ptr];

  // FIFO data array written on every accepted push.
  // NOTE: the storage array has no reset; o_count alone decides what is valid,
  // so clearing the data would only cost logic.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i8_wrdata;
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  // NOTE: all state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr_en && w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, optional parity, stop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_shift <= w_head;
`ifdef UART_TX_FIFO_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_START;
          end else begin
            r_tx <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_stop_end) begin
            r_cnt <= '0;
            if (w_start_ok) begin
              // Chain straight into the next frame with no idle gap.
              r_shift <= w_head;
`ifdef UART_TX_FIFO_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_STOP) && w_stop_end;
  assign o_uart_tx  = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with a short bit time (CPB = 8).
module tb_uart_tx_fifo;

  localparam int CPB   = 8;   // 80 Hz clock / 10 Bd
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [7:0] wrdata;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       done;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .p_BAUDRATE  (10),
    .p_CLK_FREQ  (80),
    .p_FIFO_DEPTH(DEPTH),
    .p_STOP_BITS (1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_wr_en   (wr_en),
    .i8_wrdata (wrdata),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (count),
    .o_overflow(overflow),
    .o_busy    (busy),
    .o_done    (done),
    .o_uart_tx (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the first cycle of a start bit; returns on the cycle after the
  // last stop-bit cycle. Each bit is checked on its first and last cycle.
  // i_en is dropped at the start of bit index drop_at (0 = start bit).
  task automatic expect_frame(input logic [7:0] d, input int drop_at, input string tag);
    logic [11:0] bits;
    int          n;
    bits = '0;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_TX_FIFO_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
    n = 11;
`else
    bits[9] = 1'b1;
    n = 10;
`endif
    for (int b = 0; b < n; b++) begin
      if (b == drop_at) en = 1'b0;
      check($sformatf("%s bit%0d first", tag, b), tx, bits[b]);
      if (b == n - 1) check($sformatf("%s done early", tag), done, 1'b0);
      if (b == 3) check($sformatf("%s busy", tag), busy, 1'b1);
      repeat (CPB - 1) tick();
      check($sformatf("%s bit%0d last", tag, b), tx, bits[b]);
      if (b == n - 1) check($sformatf("%s done", tag), done, 1'b1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wrdata = '0;
    repeat (3) tick();

    // Reset state
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst count", count, 5'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Single byte 0x21: line low one clock after the write edge
    wr_en = 1'b1; wrdata = 8'h21;
    tick();
    wr_en = 1'b0;
    check("single tx idle", tx, 1'b1);
    check("single count1", count, 5'd1);
    check("single empty0", empty, 1'b0);
    tick();
    check("single busy", busy, 1'b1);
    check("single count0", count, 5'd0);
    check("single empty1", empty, 1'b1);
    expect_frame(8'h21, 99, "f21");
    check("single idle tx", tx, 1'b1);
    check("single idle busy", busy, 1'b0);

    // Burst of three, queued with i_en low, then sent back-to-back
    en = 1'b0;
    wr_en = 1'b1; wrdata = 8'h55; tick();
    wrdata = 8'hAA; tick();
    wrdata = 8'h0F; tick();
    wr_en = 1'b0;
    check("burst count3", count, 5'd3);
    check("burst tx idle", tx, 1'b1);
    en = 1'b1;
    tick();
    check("burst count2", count, 5'd2);
    expect_frame(8'h55, 99, "f55");
    check("burst count1", count, 5'd1);
    expect_frame(8'hAA, 99, "fAA");
    check("burst count0", count, 5'd0);
    check("burst empty", empty, 1'b1);
    expect_frame(8'h0F, 99, "f0F");
    check("burst idle tx", tx, 1'b1);
    check("burst idle busy", busy, 1'b0);

    // Fill to full with i_en low, then one write too many
    en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wrdata = 8'h30 + 8'(i);
      tick();
    end
    check("fill count16", count, 5'd16);
    check("fill full", full, 1'b1);
    check("fill no ovf", overflow, 1'b0);
    wrdata = 8'hEE;
    tick();
    check("ovf pulse", overflow, 1'b1);
    check("ovf count16", count, 5'd16);
    check("ovf full", full, 1'b1);
    wr_en = 1'b0;
    tick();
    check("ovf one cycle", overflow, 1'b0);
    check("ovf count held", count, 5'd16);
    check("ovf line idle", tx, 1'b1);
    en = 1'b1;
    tick();
    check("drain count15", count, 5'd15);
    check("drain not full", full, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      expect_frame(8'h30 + 8'(i), 99, $sformatf("fill%0d", i));
    end
    check("drain idle tx", tx, 1'b1);
    check("drain empty", empty, 1'b1);
    repeat (2 * CPB) tick();
    check("drain no 17th tx", tx, 1'b1);
    check("drain no 17th busy", busy, 1'b0);

    // i_en dropped at data bit 3 with two bytes still queued
    en = 1'b0;
    wr_en = 1'b1; wrdata = 8'hA1; tick();
    wrdata = 8'hB2; tick();
    wrdata = 8'hC3; tick();
    wr_en = 1'b0;
    en = 1'b1;
    tick();
    check("en count2", count, 5'd2);
    expect_frame(8'hA1, 4, "fA1");
    check("en stop tx", tx, 1'b1);
    check("en stop busy", busy, 1'b0);
    repeat (3 * CPB) tick();
    check("en hold tx", tx, 1'b1);
    check("en hold count2", count, 5'd2);
    en = 1'b1;
    tick();
    check("en resume count1", count, 5'd1);
    expect_frame(8'hB2, 99, "fB2");
    expect_frame(8'hC3, 99, "fC3");
    check("en resume idle", tx, 1'b1);

    // Reset in the middle of a data bit with a byte queued
    wr_en = 1'b1; wrdata = 8'h5A; tick();
    wr_en = 1'b0;
    tick();
    check("mid start", tx, 1'b0);
    repeat (3 * CPB) tick();
    wr_en = 1'b1; wrdata = 8'h77; tick();
    wr_en = 1'b0;
    check("mid count1", count, 5'd1);
    check("mid busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("mid rst tx", tx, 1'b1);
    check("mid rst count", count, 5'd0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst empty", empty, 1'b1);
    rst = 1'b0;
    repeat (4 * CPB) tick();
    check("post rst tx", tx, 1'b1);
    check("post rst busy", busy, 1'b0);

    // Write coinciding with the pop from IDLE leaves count unchanged
    wr_en = 1'b1; wrdata = 8'h01; tick();
    check("sim count1", count, 5'd1);
    wrdata = 8'h80; tick();
    wr_en = 1'b0;
    check("sim start", tx, 1'b0);
    check("sim count held", count, 5'd1);
    expect_frame(8'h01, 99, "f01");
    check("sim count0", count, 5'd0);
    expect_frame(8'h80, 99, "f80");
    check("sim idle", tx, 1'b1);
    check("sim idle busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
